// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: digit/point widths
// used by both the scheduler and the dynamic scan driver, plus the scheduler
// state encoding.
package seg_pkg;

    localparam int SEG_DATA_W = 20;
    localparam int SEG_PNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } seg_state_e;

    // Larger of two integers, used to size the shared dwell/blank counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_disp_sched_if.sv
// Bundle between the content sources and the display scheduler. The source
// side drives requests and per-source content; the scheduler drives the
// display fields and the grant vector.
interface seg_disp_sched_if
    import seg_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            urgent;
    logic [SEG_DATA_W*N_REQ-1:0] src_data;
    logic [SEG_PNT_W*N_REQ-1:0]  src_point;
    logic [N_REQ-1:0]            src_sign;
    logic [SEG_DATA_W-1:0]       data;
    logic [SEG_PNT_W-1:0]        point;
    logic                        sign;
    logic                        seg_en;
    logic [N_REQ-1:0]            grant;

    modport master (
        output req, urgent, src_data, src_point, src_sign,
        input  data, point, sign, seg_en, grant
    );

    modport slave (
        input  req, urgent, src_data, src_point, src_sign,
        output data, point, sign, seg_en, grant
    );
endinterface

// File: rtl/seg_rr_pick.sv
// Combinational selector: lowest-index urgent requester wins outright,
// otherwise round-robin search starting just after the last served index.
module seg_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] urgent,
    input  logic [PTR_W-1:0] last,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [N_REQ-1:0] urg_req;
    logic [PTR_W-1:0] cand_idx;

    assign urg_req = urgent & req;

    // Walk candidates from farthest to nearest so the nearest set bit is the
    // final assignment; then let the lowest urgent index override.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_idx = PTR_W'((int'(last) + k) % N_REQ);
            if (req[cand_idx]) begin
                pick_idx = cand_idx;
                pick_vld = 1'b1;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_idx = PTR_W'(i);
            if (urg_req[cand_idx]) begin
                pick_idx = cand_idx;
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares one 6-digit display between N_REQ sources: round-robin turns of
// DWELL_CYC cycles separated by BLANK_CYC dark cycles, with urgent preemption.
module seg_disp_sched
    import seg_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DWELL_CYC = 100_000_000,
    parameter int BLANK_CYC = 2_500_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    seg_disp_sched_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(DWELL_CYC, BLANK_CYC));
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    seg_state_e             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [PTR_W-1:0]       last_reg;
    logic [SEG_DATA_W-1:0]  data_reg;
    logic [SEG_PNT_W-1:0]   point_reg;
    logic                   sign_reg;
    logic                   seg_en_reg;
    logic [N_REQ-1:0]       grant_reg;

    logic [SEG_DATA_W-1:0]  slice_data  [N_REQ];
    logic [SEG_PNT_W-1:0]   slice_point [N_REQ];

    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [N_REQ-1:0]       pick_onehot;
    logic [N_REQ-1:0]       last_onehot;
    logic                   cur_req;
    logic                   cur_urg;
    logic                   other_urg;

    // Unpack the flat per-source buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice_data[gi]  = bus.src_data[gi*SEG_DATA_W +: SEG_DATA_W];
            assign slice_point[gi] = bus.src_point[gi*SEG_PNT_W +: SEG_PNT_W];
        end
    endgenerate

    seg_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req      (bus.req),
        .urgent   (bus.urgent),
        .last     (last_reg),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // One-hot forms of the candidate pick and of the currently shown index.
    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
        last_onehot           = '0;
        last_onehot[last_reg] = 1'b1;
    end

    // While showing, last_reg is the granted index; preemption needs another
    // urgent requester while the shown source itself is not urgent.
    assign cur_req   = bus.req[last_reg];
    assign cur_urg   = bus.urgent[last_reg] & bus.req[last_reg];
    assign other_urg = |(bus.urgent & bus.req & ~last_onehot);

    // Scheduler FSM with registered display outputs and a shared phase counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            last_reg   <= PTR_W'(N_REQ - 1);
            data_reg   <= '0;
            point_reg  <= '0;
            sign_reg   <= 1'b0;
            seg_en_reg <= 1'b0;
            grant_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Display is already dark, so a new source starts at once.
                    if (pick_vld) begin
                        state_reg  <= ST_SHOW;
                        cnt_reg    <= '0;
                        last_reg   <= pick_idx;
                        grant_reg  <= pick_onehot;
                        seg_en_reg <= 1'b1;
                        data_reg   <= slice_data[pick_idx];
                        point_reg  <= slice_point[pick_idx];
                        sign_reg   <= bus.src_sign[pick_idx];
                    end
                end
                ST_SHOW: begin
                    // Track live source content every cycle of the turn.
                    data_reg  <= slice_data[last_reg];
                    point_reg <= slice_point[last_reg];
                    sign_reg  <= bus.src_sign[last_reg];
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (!cur_req || (other_urg && !cur_urg)) begin
                        state_reg  <= ST_BLANK;
                        cnt_reg    <= '0;
                        seg_en_reg <= 1'b0;
                        grant_reg  <= '0;
                    end else if (cnt_reg == DWELL_LAST) begin
                        if (pick_idx != last_reg) begin
                            state_reg  <= ST_BLANK;
                            cnt_reg    <= '0;
                            seg_en_reg <= 1'b0;
                            grant_reg  <= '0;
                        end else begin
                            // Sole or urgent requester: renew the turn, no gap.
                            cnt_reg <= '0;
                        end
                    end
                end
                ST_BLANK: begin
                    // Fixed-length gap; the winner is chosen on its last cycle.
                    if (cnt_reg == BLANK_LAST) begin
                        cnt_reg <= '0;
                        if (pick_vld) begin
                            state_reg  <= ST_SHOW;
                            last_reg   <= pick_idx;
                            grant_reg  <= pick_onehot;
                            seg_en_reg <= 1'b1;
                            data_reg   <= slice_data[pick_idx];
                            point_reg  <= slice_point[pick_idx];
                            sign_reg   <= bus.src_sign[pick_idx];
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    cnt_reg    <= '0;
                    seg_en_reg <= 1'b0;
                    grant_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.data   = data_reg;
    assign bus.point  = point_reg;
    assign bus.sign   = sign_reg;
    assign bus.seg_en = seg_en_reg;
    assign bus.grant  = grant_reg;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed scenarios followed by random traffic,
// every cycle compared against a turn-based behavioural model.
module tb_seg_disp_sched;
    import seg_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BC = 2;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    always #5 sys_clk = ~sys_clk;

    seg_disp_sched_if #(.N_REQ(N)) bus ();

    seg_disp_sched #(
        .N_REQ     (N),
        .DWELL_CYC (DW),
        .BLANK_CYC (BC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a source is either on screen, in a gap, or nothing is shown.
    int          m_mode;   // 0 = dark/idle, 1 = showing, 2 = gap
    int          m_src;
    int          m_last;
    int          m_shown;  // cycles the current source has been on screen this turn
    int          m_gap;    // gap cycles elapsed
    logic [19:0] m_data;
    logic [5:0]  m_point;
    logic        m_sign;

    function automatic int ref_pick();
        for (int i = 0; i < N; i++)
            if (bus.urgent[i] && bus.req[i]) return i;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (bus.req[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_src = 0; m_last = N - 1; m_shown = 0; m_gap = 0;
        m_data = '0; m_point = '0; m_sign = 1'b0;
    endtask

    task automatic model_load(input int s);
        m_data  = bus.src_data[s*20 +: 20];
        m_point = bus.src_point[s*6 +: 6];
        m_sign  = bus.src_sign[s];
    endtask

    task automatic model_show(input int s);
        m_mode = 1; m_src = s; m_last = s; m_shown = 0;
        model_load(s);
    endtask

    task automatic model_gap();
        m_mode = 2; m_gap = 0;
    endtask

    task automatic model_clock();
        int p;
        logic [3:0] others;
        case (m_mode)
            0: begin
                p = ref_pick();
                if (p >= 0) model_show(p);
            end
            1: begin
                model_load(m_src);
                m_shown++;
                others = bus.urgent & bus.req & ~(4'b0001 << m_src);
                if (!bus.req[m_src] || (others != 0 && !bus.urgent[m_src])) model_gap();
                else if (m_shown == DW) begin
                    p = ref_pick();
                    if (p != m_src) model_gap();
                    else m_shown = 0;
                end
            end
            default: begin
                m_gap++;
                if (m_gap == BC) begin
                    p = ref_pick();
                    if (p >= 0) model_show(p);
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    // One clock: advance model at the edge, compare on the falling edge.
    task automatic tick();
        logic [3:0] eg;
        @(posedge sys_clk);
        model_clock();
        @(negedge sys_clk);
        eg = (m_mode == 1) ? (4'b0001 << m_src) : 4'b0000;
        check_val("grant",  32'(bus.grant),  32'(eg));
        check_val("seg_en", 32'(bus.seg_en), 32'(m_mode == 1));
        check_val("data",   32'(bus.data),   32'(m_data));
        check_val("point",  32'(bus.point),  32'(m_point));
        check_val("sign",   32'(bus.sign),   32'(m_sign));
    endtask

    int lows;
    int budget;

    initial begin
        sys_rst_n     = 1'b0;
        bus.req       = '0;
        bus.urgent    = '0;
        bus.src_data  = '0;
        bus.src_point = '0;
        bus.src_sign  = '0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_val("rst_seg_en", 32'(bus.seg_en), 32'd0);
        check_val("rst_grant",  32'(bus.grant),  32'd0);
        check_val("rst_data",   32'(bus.data),   32'd0);
        sys_rst_n = 1'b1;

        // Nothing requested: display stays dark.
        repeat (20) tick();

        // Two sources alternate with gaps.
        bus.src_data  = {20'h0, 20'h00987, 20'h0, 20'h12345};
        bus.src_point = {6'h00, 6'h05, 6'h00, 6'h21};
        bus.src_sign  = 4'b0100;
        bus.req       = 4'b0101;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1)  check_val("rr_first",  32'(bus.grant), 32'h1);
            if (c == 8)  check_val("rr_dwell",  32'(bus.grant), 32'h1);
            if (c == 9)  check_val("rr_gap",    32'(bus.seg_en), 32'h0);
            if (c == 11) check_val("rr_second", 32'(bus.grant), 32'h4);
            if (c == 11) check_val("rr_data2",  32'(bus.data),  32'h00987);
            if (c == 21) check_val("rr_back",   32'(bus.grant), 32'h1);
        end
        bus.req = 4'b0000;
        repeat (4) tick();

        // Single source: continuous display without gaps.
        bus.req = 4'b0010;
        bus.src_data[39:20] = 20'h55555;
        tick();
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!bus.seg_en) lows++;
        end
        check_val("solo_no_gap", 32'(lows), 32'd0);

        // Urgent preemption at dwell count 3.
        budget = 0;
        while (!(m_mode == 1 && m_src == 1 && m_shown == 3) && budget < 20) begin
            tick();
            budget++;
        end
        check_val("urg_setup", 32'(bus.grant), 32'h2);
        bus.src_data[79:60] = 20'h99001;
        bus.req    = 4'b1010;
        bus.urgent = 4'b1000;
        tick();
        check_val("urg_blank1", 32'(bus.seg_en), 32'h0);
        tick();
        check_val("urg_blank2", 32'(bus.seg_en), 32'h0);
        tick();
        check_val("urg_grant", 32'(bus.grant), 32'h8);
        repeat (20) tick();
        check_val("urg_hold", 32'(bus.grant), 32'h8);

        // Drop of the only remaining request ends in idle.
        bus.urgent = 4'b0000;
        bus.req    = 4'b0001;
        budget = 0;
        while (!(m_mode == 1 && m_src == 0) && budget < 40) begin
            tick();
            budget++;
        end
        check_val("drop_setup", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        repeat (3) tick();
        check_val("drop_idle", 32'(bus.seg_en), 32'h0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a turn.
        bus.src_data = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
        bus.req = 4'b1111;
        repeat (4) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_val("arst_seg_en", 32'(bus.seg_en), 32'd0);
        check_val("arst_grant",  32'(bus.grant),  32'd0);
        check_val("arst_data",   32'(bus.data),   32'd0);
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        check_val("arst_first", 32'(bus.grant), 32'h1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) bus.req = 4'($urandom);
            if ($urandom_range(15) == 0) bus.urgent = 4'($urandom) & 4'($urandom);
            if ($urandom_range(3) == 0) begin
                bus.src_data  = 80'({$urandom, $urandom, $urandom});
                bus.src_point = 24'($urandom);
                bus.src_sign  = 4'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Display scheduler in front of `seg_595_dynamic`. It time-shares the single 6-digit seven-segment display between `N_REQ` content sources (clock, temperature, alarm, etc.). Sources are served in round-robin order with a fixed dwell time and a blank gap between sources. Urgent sources preempt the rotation. Outputs drive `data`/`point`/`sign`/`seg_en` of the display path directly.

## Interface
- `N_REQ`, 4: number of requesters; index 0 is the lowest index.
- `DWELL_CYC`, 100_000_000: cycles each source is shown per turn (2 s at 50 MHz); must be ≥ 2.
- `BLANK_CYC`, 2_500_000: cycles of blank display between different sources (50 ms); must be ≥ 1.
- `sys_clk`  in  1  system clock, 50 MHz; single clock domain.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  level: source i has content to show.
- `urgent`  in  N_REQ  level: source i demands immediate display; ignored unless matching `req` bit is also high.
- `src_data`  in  20*N_REQ  BCD-packed value per source; slice i = [20*i+19 : 20*i].
- `src_point`  in  6*N_REQ  decimal points per source.
- `src_sign`  in  N_REQ  minus sign per source.
- `data`  out  20  value to display (registered).
- `point`  out  6  decimal points (registered).
- `sign`  out  1  sign (registered).
- `seg_en`  out  1  display enable (registered).
- `grant`  out  N_REQ  one-hot index of the source being shown; 0 when none.

## Operation
- FSM states: IDLE, SHOW, BLANK. Reset state is IDLE. Reset values: `data`=0, `point`=0, `sign`=0, `seg_en`=0, `grant`=0, dwell counter=0, round-robin pointer `last`=N_REQ-1.
- Pick function, applied to `req`:
  - If any bit of `urgent & req` is set, pick its lowest index.
  - Otherwise pick the first set bit of `req` searching upward from `last+1`, wrapping modulo N_REQ.
  - If nothing is set, there is no pick.
- IDLE:
  - If any `req` is set, go to SHOW with `grant`=pick, `last`=pick, dwell counter=0.
  - The blank gap is skipped here because the display is already dark.
- SHOW:
  - Every cycle, `data`/`point`/`sign` are copied from the granted slice, so live updates of the source are shown. `seg_en`=1.
  - Dwell counter increments each cycle.
  - Priority of exits, evaluated each cycle:
    1. Granted `req` bit drops: go to BLANK.
    2. Another index has `urgent&req` while the granted index does not: go to BLANK (preemption).
    3. Counter reaches DWELL_CYC-1: if pick ≠ current grant, go to BLANK; if pick = current grant, which means it is the only requester or it is urgent, clear the counter and stay.
- BLANK:
  - `seg_en`=0, `grant`=0, `data`/`point`/`sign` held.
  - The blank counter runs BLANK_CYC cycles. On the last cycle, re-evaluate pick: if there is a pick, go to SHOW with new grant and `last` update; if there is none, go to IDLE.
  - Requests or urgents that arrive during BLANK never shorten the blank.
- Widths:
  - Counters are `$clog2(max(DWELL_CYC, BLANK_CYC))` bits.
  - Round-robin pointer is `$clog2(N_REQ)` bits, minimum 1.
  - No arithmetic on data; slices are passed bit-exact.

## Timing
- All outputs are registered. Change of `req`/`urgent` at edge t is reflected in `grant`/`seg_en` at edge t+1.
- Source data in SHOW appears on `data` 1 cycle after `src_data` changes.
- Uninterrupted turn: `seg_en`=1 for exactly DWELL_CYC cycles, then exactly BLANK_CYC cycles of `seg_en`=0, then the next source.
- Simultaneous granted-`req` drop and dwell expiry: the drop wins (BLANK). The outcome is identical either way.
- An `urgent` asserted for the currently granted source only extends its dwell; it never causes a blank.
- Asynchronous reset mid-SHOW or mid-BLANK: all outputs clear immediately, go to IDLE, `last` reinitialised.

## Structure
- Shared package `seg_pkg`:
  - `SEG_DATA_W`=20 and `SEG_PNT_W`=6; also used by `seg_dynamic`.
  - State enum for IDLE/SHOW/BLANK.
- Sub-module `seg_rr_pick`: purely combinational; inputs `req`, `urgent`, `last`; outputs `pick_idx`, `pick_vld`. Reused by any future resource arbiter.
- Top holds FSM, counters, and output registers.

## Test plan
All scenarios use `DWELL_CYC`=8, `BLANK_CYC`=2, `N_REQ`=4.
- Reset then `req`=4'b0000 for 20 cycles → `seg_en`=0, `grant`=0, `data`=0 throughout.
- `req`=4'b0101, `src_data` slice0=20'h12345, slice2=20'h00987 → grant 0001 for 8 cycles, 2 blank cycles, 0100 for 8, 2 blank, 0001; `data` matches the granted slice.
- `req`=4'b0010 only → `grant`=0010 continuously, `seg_en` never drops, no blank gaps across 40 cycles.
- Showing source 1, assert `urgent`=4'b1000 with `req`=4'b1010 at dwell count 3 → next cycle `seg_en`=0 for 2 cycles, then `grant`=1000; it stays while urgent is held, even past dwell expiry.
- Showing source 0, drop `req[0]` with `req`=0 otherwise → 2 blank cycles, then IDLE, `seg_en`=0.
- Assert `sys_rst_n`=0 mid-SHOW asynchronously (between clock edges) → `seg_en`, `grant`, and `data` are 0 before the next clock edge; after release with `req`=4'b1111, first grant is 0001.
